// File: rtl/pic_rom_streamer.sv
// pic_rom_streamer
// Reads a picture out of a single-port ROM and presents it as a valid/ready
// pixel stream with start-of-frame, end-of-line and end-of-frame markers.
// Reads are issued only while in-flight reads plus buffered pixels leave room
// in the output FIFO, so downstream backpressure never loses a ROM word.
// The first read is issued in the start cycle, so the first beat appears
// RD_LATENCY+1 cycles after start.
module pic_rom_streamer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int EW   = DATA_WIDTH + 3;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
  localparam logic [ADDR_WIDTH-1:0] X_LAST    = ADDR_WIDTH'(IMG_W - 1);
  localparam logic [PW-1:0]         PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]           DEPTH_C   = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Number of reads still travelling through the ROM latency pipe.
  function automatic logic [CW-1:0] popcount(input logic [RD_LATENCY-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  // FIFO pointer advance with wrap for any depth.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PTR_LAST) begin
      r = '0;
    end else begin
      r = p + PW'(1);
    end
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] x_q, x_d;
  logic [ADDR_WIDTH-1:0] y_q, y_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;

  logic [RD_LATENCY-1:0] pv_q;
  logic [2:0]            pt_q [RD_LATENCY];

  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         cnt_q;

  logic                  issue_s;
  logic                  done_s;
  logic                  credit_ok_s;
  logic [CW-1:0]         inflight_s;
  logic [2:0]            tag_s;
  logic                  push_s;
  logic                  pop_s;
  logic [EW-1:0]         head_s;

  assign inflight_s  = popcount(pv_q);
  assign credit_ok_s = ({1'b0, inflight_s} + {1'b0, cnt_q}) < DEPTH_C;
  assign tag_s       = {addr_q == '0, x_q == X_LAST, addr_q == LAST_ADDR};

  assign push_s  = pv_q[RD_LATENCY-1];
  assign m_valid = (cnt_q != '0);
  assign pop_s   = m_valid && m_ready;
  assign head_s  = mem_q[rd_ptr_q];

  assign m_data  = m_valid ? head_s[DATA_WIDTH-1:0] : '0;
  assign m_sof   = m_valid && head_s[EW-1];
  assign m_eol   = m_valid && head_s[EW-2];
  assign m_eof   = m_valid && head_s[EW-3];

  assign rom_addr = issue_s ? addr_q : last_addr_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_s;

  // Frame sequencing: decide when to issue a read and when the frame is done.
  always_comb begin
    state_d = state_q;
    issue_s = 1'b0;
    done_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          issue_s = credit_ok_s;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (credit_ok_s) begin
          issue_s = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        // One entry left with nothing in flight means the head is the final pixel.
        if ((pv_q == '0) && (cnt_q == CW'(1)) && m_ready) begin
          done_s  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Address, column and line counters; they return to zero after the last pixel.
  always_comb begin
    addr_d      = addr_q;
    x_d         = x_q;
    y_d         = y_q;
    last_addr_d = last_addr_q;
    if (issue_s) begin
      last_addr_d = addr_q;
      if (addr_q == LAST_ADDR) begin
        addr_d = '0;
        x_d    = '0;
        y_d    = '0;
      end else begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = y_q + ADDR_WIDTH'(1);
        end else begin
          x_d = x_q + ADDR_WIDTH'(1);
          y_d = y_q;
        end
      end
    end else begin
      last_addr_d = last_addr_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      last_addr_q <= last_addr_d;
    end
  end

  // Tag pipe tracking which ROM output cycles carry a requested pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pt_q[i] <= 3'b000;
      end
    end else begin
      pv_q[0] <= issue_s;
      pt_q[0] <= tag_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pt_q[i] <= pt_q[i-1];
      end
    end
  end

  // FIFO storage: capture ROM data with its markers when a tagged slot matures.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {pt_q[RD_LATENCY-1], rom_rd_data};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
